// File: rtl/acorn_encrypt_process.sv
// acorn_encrypt_process: bit-serial ACORN-128 plaintext encryption and padding stage
//   clk, rst        clock, asynchronous active-low reset
//   start_i         one-cycle pulse in IDLE: load state_in_i, begin a message
//   msg_empty_i     sampled with start_i: zero-length plaintext, go straight to padding
//   state_in_i      state from the associated-data stage
//   pt_valid_i/pt_bit_i/pt_last_i/pt_ready_o   plaintext bit stream
//   ct_valid_o/ct_bit_o                        ciphertext bit stream, one cycle after accept
//   busy_o, done_o, bit_count_o                status
//   state_out_o     final state for the tag stage, valid from done_o until next start
module acorn_encrypt_process #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             msg_empty_i,
  input  logic [292:0]     state_in_i,
  input  logic             pt_valid_i,
  input  logic             pt_bit_i,
  input  logic             pt_last_i,
  output logic             pt_ready_o,
  output logic             ct_valid_o,
  output logic             ct_bit_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] bit_count_o,
  output logic [292:0]     state_out_o
);
  typedef enum logic [1:0] {IDLE, DATA, PAD, DONE} st_t;
  st_t state_q, state_d;
  logic [292:0] s_q, s_d, out_q, out_d, s_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] pad_q, pad_d;
  logic ctv_q, ctv_d, ctb_q, ctb_d;
  logic acc, m, ca, ks;
  // One ACORN step; the six feedback lines are applied in order on a working copy,
  // returns {ks, shifted state}.
  function automatic logic [293:0] step(input logic [292:0] s0, input logic mi, input logic cai, input logic cbi);
    logic [292:0] s;
    logic k, f;
    s = s0;
    s[289] ^= s[235] ^ s[230];
    s[230] ^= s[196] ^ s[193];
    s[193] ^= s[160] ^ s[154];
    s[154] ^= s[111] ^ s[107];
    s[107] ^= s[66] ^ s[61];
    s[61]  ^= s[23] ^ s[0];
    k = s[12] ^ s[154] ^ (s[235] & s[61] ^ s[235] & s[193] ^ s[61] & s[193])
        ^ (s[230] & s[111] ^ ~s[230] & s[66]);
    f = s[0] ^ ~s[107] ^ (s[244] & s[23] ^ s[244] & s[160] ^ s[23] & s[160])
        ^ (cai & s[196]) ^ (cbi & k) ^ mi;
    return {k, f, s[292:1]};
  endfunction
  assign acc = state_q == DATA && pt_valid_i;
  assign m = state_q == DATA ? pt_bit_i : pad_q == 8'd0;
  assign ca = state_q == DATA || !pad_q[7];
  assign {ks, s_nxt} = step(s_q, m, ca, 1'b0);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      s_q <= '0;
      out_q <= '0;
      cnt_q <= '0;
      pad_q <= '0;
      ctv_q <= 1'b0;
      ctb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      out_q <= out_d;
      cnt_q <= cnt_d;
      pad_q <= pad_d;
      ctv_q <= ctv_d;
      ctb_q <= ctb_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start_i ? (msg_empty_i ? PAD : DATA) : IDLE;
      DATA: state_d = acc && pt_last_i ? PAD : DATA;
      PAD:  state_d = &pad_q ? DONE : PAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    s_d = s_q;
    out_d = out_q;
    cnt_d = cnt_q;
    pad_d = pad_q;
    ctv_d = 1'b0;
    ctb_d = ctb_q;
    if (state_q == IDLE && start_i) begin
      s_d = state_in_i;
      cnt_d = '0;
      pad_d = '0;
    end
    if (acc) begin
      s_d = s_nxt;
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
      ctv_d = 1'b1;
      ctb_d = pt_bit_i ^ ks;
    end
    // the final padding step result goes straight to state_out so it is valid with done
    if (state_q == PAD) begin
      s_d = s_nxt;
      pad_d = pad_q + 8'd1;
      out_d = &pad_q ? s_nxt : out_q;
    end
  end
  always_comb begin
    pt_ready_o = state_q == DATA;
    busy_o = state_q == DATA || state_q == PAD;
    done_o = state_q == DONE;
  end
  assign ct_valid_o = ctv_q;
  assign ct_bit_o = ctb_q;
  assign bit_count_o = cnt_q;
  assign state_out_o = out_q;
endmodule

// File: tb/tb_acorn_encrypt_process.sv
// tb_acorn_encrypt_process: directed checks of the ACORN encryption stage against a bench-side step model
module tb_acorn_encrypt_process;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, msg_empty = 1'b0;
  logic pt_valid = 1'b0, pt_bit = 1'b0, pt_last = 1'b0;
  logic [292:0] state_in = '0;
  logic pt_ready, ct_valid, ct_bit, busy, done;
  logic [15:0] bit_count;
  logic [292:0] state_out;
  int checks = 0, failures = 0;
  bit msg[256];
  bit ct_got[256];
  bit ct_exp[256];
  bit ct_ref[256];
  int nct, done_cyc, acc_cyc, ct_cyc, saw_ready;
  logic [292:0] fin, exp_s, ref_s, kat_s;
  logic [15:0] fin_cnt;

  acorn_encrypt_process #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .msg_empty_i(msg_empty), .state_in_i(state_in),
    .pt_valid_i(pt_valid), .pt_bit_i(pt_bit), .pt_last_i(pt_last), .pt_ready_o(pt_ready),
    .ct_valid_o(ct_valid), .ct_bit_o(ct_bit), .busy_o(busy), .done_o(done),
    .bit_count_o(bit_count), .state_out_o(state_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [292:0] rnd();
    logic [319:0] r;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom();
    return r[292:0];
  endfunction

  task automatic mstep(inout logic [292:0] s, input bit mi, input bit cai, output bit k);
    bit t289, t230, t193, t154, t107, t61, f;
    t289 = s[289] ^ s[235] ^ s[230];
    t230 = s[230] ^ s[196] ^ s[193];
    t193 = s[193] ^ s[160] ^ s[154];
    t154 = s[154] ^ s[111] ^ s[107];
    t107 = s[107] ^ s[66] ^ s[61];
    t61  = s[61] ^ s[23] ^ s[0];
    k = s[12] ^ t154 ^ ((s[235] & t61) | (s[235] & t193) | (t61 & t193)) ^ (t230 ? s[111] : s[66]);
    f = s[0] ^ !t107 ^ ((s[244] & s[23]) | (s[244] & s[160]) | (s[23] & s[160])) ^ (cai & s[196]) ^ mi;
    s = s >> 1;
    s[292] = f;
    s[288] = t289;
    s[229] = t230;
    s[192] = t193;
    s[153] = t154;
    s[106] = t107;
    s[60]  = t61;
  endtask

  task automatic model(input logic [292:0] s0, input int len);
    logic [292:0] s;
    bit k;
    s = s0;
    for (int i = 0; i < len; i++) begin
      mstep(s, msg[i], 1'b1, k);
      ct_exp[i] = msg[i] ^ k;
    end
    for (int j = 0; j < 256; j++) mstep(s, j == 0, j < 128, k);
    exp_s = s;
  endtask

  task automatic run(input logic [292:0] s0, input bit empty, input int len, input bit gaps, input bit extra);
    int i, cyc;
    i = 0;
    cyc = 1;
    nct = 0; done_cyc = 0; acc_cyc = 0; ct_cyc = 0; saw_ready = 0;
    @(negedge clk);
    state_in = s0; msg_empty = empty; start = 1'b1;
    while (done_cyc == 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      start = extra && (cyc == 4 || cyc == 150);
      if (start) begin state_in = ~s0; msg_empty = ~empty; end
      if (ct_valid && nct < 256) begin
        if (nct == 0) ct_cyc = cyc;
        ct_got[nct] = ct_bit;
        nct++;
      end
      if (pt_ready) saw_ready = 1;
      if (done) begin done_cyc = cyc; fin = state_out; fin_cnt = bit_count; end
      pt_valid = pt_ready && i < len && !(gaps && cyc[0]);
      pt_bit = pt_valid ? msg[i] : 1'($urandom_range(0, 1));
      pt_last = i < len && i == len - 1;
      if (pt_valid) begin acc_cyc = cyc; i++; end
    end
    start = 1'b0; pt_valid = 1'b0; pt_last = 1'b0; msg_empty = 1'b0;
    checks++;
    if (done_cyc == 0) begin failures++; $display("FAIL run_timeout done not seen within budget"); end
  endtask

  task automatic test_reset();
    #23;
    checks++; if (pt_ready !== 1'b0) begin failures++; $display("FAIL rst_pt_ready got=%b exp=0", pt_ready); end
    checks++; if (ct_valid !== 1'b0 || ct_bit !== 1'b0) begin failures++; $display("FAIL rst_ct got=%b%b exp=00", ct_valid, ct_bit); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL rst_busy_done got=%b%b exp=00", busy, done); end
    checks++; if (bit_count !== 16'd0) begin failures++; $display("FAIL rst_bit_count got=%0d exp=0", bit_count); end
    checks++; if (state_out !== '0) begin failures++; $display("FAIL rst_state_out got=%h exp=0", state_out); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pt_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_release_idle got=%b%b exp=00", pt_ready, busy); end
  endtask

  task automatic test_single_zero();
    msg[0] = 1'b1;
    model('0, 1);
    run('0, 1'b0, 1, 1'b0, 1'b0);
    checks++; if (nct !== 1 || ct_got[0] !== 1'b1) begin failures++; $display("FAIL single_ct got_n=%0d got_bit=%b exp_n=1 exp_bit=1", nct, ct_got[0]); end
    checks++; if (ct_cyc - acc_cyc !== 1) begin failures++; $display("FAIL single_ct_latency got=%0d exp=1", ct_cyc - acc_cyc); end
    checks++; if (done_cyc - acc_cyc !== 257) begin failures++; $display("FAIL single_done_latency got=%0d exp=257", done_cyc - acc_cyc); end
    checks++; if (fin_cnt !== 16'd1) begin failures++; $display("FAIL single_bit_count got=%0d exp=1", fin_cnt); end
    checks++; if (fin !== exp_s) begin failures++; $display("FAIL single_state got=%h exp=%h", fin, exp_s); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_done_pulse got=%b%b exp=00", done, busy); end
    repeat (3) @(negedge clk);
    checks++; if (state_out !== exp_s) begin failures++; $display("FAIL single_state_hold got=%h exp=%h", state_out, exp_s); end
  endtask

  task automatic test_ks_one();
    logic [292:0] s;
    s = '0;
    s[12] = 1'b1;
    msg[0] = 1'b0;
    run(s, 1'b0, 1, 1'b0, 1'b0);
    checks++; if (nct !== 1 || ct_got[0] !== 1'b1) begin failures++; $display("FAIL ks_one_ct got_n=%0d got_bit=%b exp_n=1 exp_bit=1", nct, ct_got[0]); end
  endtask

  task automatic test_empty();
    logic [292:0] s;
    s = rnd();
    model(s, 0);
    run(s, 1'b1, 0, 1'b0, 1'b0);
    checks++; if (saw_ready !== 0) begin failures++; $display("FAIL empty_pt_ready got=1 exp=0"); end
    checks++; if (nct !== 0) begin failures++; $display("FAIL empty_ct_valid got=%0d exp=0", nct); end
    checks++; if (done_cyc !== 258) begin failures++; $display("FAIL empty_done_cycle got=%0d exp=258", done_cyc); end
    checks++; if (fin_cnt !== 16'd0) begin failures++; $display("FAIL empty_bit_count got=%0d exp=0", fin_cnt); end
    checks++; if (fin !== exp_s) begin failures++; $display("FAIL empty_state got=%h exp=%h", fin, exp_s); end
  endtask

  task automatic test_bubbled();
    logic [292:0] s;
    int bad;
    s = rnd();
    for (int i = 0; i < 64; i++) msg[i] = 1'($urandom_range(0, 1));
    model(s, 64);
    run(s, 1'b0, 64, 1'b1, 1'b0);
    for (int i = 0; i < 64; i++) ct_ref[i] = ct_got[i];
    ref_s = fin;
    checks++; if (nct !== 64) begin failures++; $display("FAIL bubble_ct_pulses got=%0d exp=64", nct); end
    checks++; if (done_cyc - acc_cyc !== 257) begin failures++; $display("FAIL bubble_done_latency got=%0d exp=257", done_cyc - acc_cyc); end
    run(s, 1'b0, 64, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ct_ref[i] !== ct_got[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bubble_vs_gapfree_ct got_diff=%0d exp=0", bad); end
    checks++; if (ref_s !== fin) begin failures++; $display("FAIL bubble_vs_gapfree_state got=%h exp=%h", ref_s, fin); end
    bad = 0;
    for (int i = 0; i < 64; i++) if (ct_got[i] !== ct_exp[i]) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL bubble_ct_model got_diff=%0d exp=0", bad); end
    checks++; if (fin !== exp_s) begin failures++; $display("FAIL bubble_state_model got=%h exp=%h", fin, exp_s); end
    checks++; if (fin_cnt !== 16'd64) begin failures++; $display("FAIL bubble_bit_count got=%0d exp=64", fin_cnt); end
  endtask

  task automatic test_kat(input bit extra);
    int bad;
    for (int k = 0; k < 293; k++) kat_s[k] = ((k * 7 + 3) % 5) < 2;
    for (int i = 0; i < 128; i++) msg[i] = bit'(((i / 8) >> (i % 8)) & 1);
    model(kat_s, 128);
    run(kat_s, 1'b0, 128, 1'b0, extra);
    bad = 0;
    for (int i = 0; i < 128; i++) if (ct_got[i] !== ct_exp[i]) bad++;
    checks++; if (nct !== 128) begin failures++; $display("FAIL kat_ct_pulses extra=%0b got=%0d exp=128", extra, nct); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL kat_ct extra=%0b got_diff=%0d exp=0", extra, bad); end
    checks++; if (fin !== exp_s) begin failures++; $display("FAIL kat_state extra=%0b got=%h exp=%h", extra, fin, exp_s); end
    checks++; if (fin_cnt !== 16'd128) begin failures++; $display("FAIL kat_bit_count extra=%0b got=%0d exp=128", extra, fin_cnt); end
    checks++; if (done_cyc !== 386) begin failures++; $display("FAIL kat_done_cycle extra=%0b got=%0d exp=386", extra, done_cyc); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    state_in = rnd(); msg_empty = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      pt_valid = 1'b1; pt_bit = 1'b1; pt_last = 1'b0;
      @(negedge clk);
    end
    checks++; if (busy !== 1'b1 || ct_valid !== 1'b1 || bit_count !== 16'd6) begin failures++; $display("FAIL mid_pre got_busy=%b got_ctv=%b got_cnt=%0d exp=1 1 6", busy, ct_valid, bit_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (pt_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mid_ctrl got=%b%b%b exp=000", pt_ready, busy, done); end
    checks++; if (ct_valid !== 1'b0 || ct_bit !== 1'b0) begin failures++; $display("FAIL mid_ct got=%b%b exp=00", ct_valid, ct_bit); end
    checks++; if (bit_count !== 16'd0) begin failures++; $display("FAIL mid_bit_count got=%0d exp=0", bit_count); end
    checks++; if (state_out !== '0) begin failures++; $display("FAIL mid_state_out got=%h exp=0", state_out); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (pt_ready !== 1'b0 || busy !== 1'b0 || bit_count !== 16'd0) begin failures++; $display("FAIL mid_after_release got_ready=%b got_busy=%b got_cnt=%0d exp=0 0 0", pt_ready, busy, bit_count); end
    pt_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_zero();
    test_ks_one();
    test_empty();
    test_bubbled();
    test_kat(1'b0);
    test_kat(1'b1);
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/acorn_encrypt_process.md
Name: acorn_encrypt_process

Overview:
- Bit-serial ACORN-128 encryption stage, directly downstream of the associated-data stage.
- Takes the 293-bit state left after associated-data absorption and absorbs plaintext one bit per accepted beat, emitting one ciphertext bit per beat.
- Then runs the 256-step plaintext padding (one 1, then 255 zeros, with the ca schedule).
- Hands the final state to the finalization/tag stage.
- Contains its own one-step ACORN state-update datapath.

Parameters:
- CNT_W, 16, width of plaintext bit counter; messages longer than 2^CNT_W-1 bits are unsupported.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- start  input  1  one-cycle pulse; loads state_in and begins encryption
- msg_empty  input  1  sampled with start; 1 = zero-length plaintext, skip directly to padding
- state_in  input  293  state from associated-data stage, valid when start=1
- pt_valid  input  1  plaintext bit valid
- pt_bit  input  1  plaintext bit
- pt_last  input  1  qualifies pt_bit as final plaintext bit
- pt_ready  output  1  block accepts a plaintext bit this cycle
- ct_valid  output  1  ciphertext bit valid (one-cycle pulse per accepted bit)
- ct_bit  output  1  ciphertext bit
- busy  output  1  high from cycle after start until done
- done  output  1  one-cycle pulse when padding completes
- bit_count  output  CNT_W  number of plaintext bits accepted since start
- state_out  output  293  final state, valid from done onward, held until next start

Behaviour:
- Reset (rst=0, async): FSM=IDLE; state register, state_out, bit_count, pad counter = 0; pt_ready, ct_valid, ct_bit, busy, done = 0.
- FSM states and transitions:
  - IDLE --start--> DATA, or PAD if msg_empty=1. Load state reg <= state_in; clear bit_count and pad counter.
  - DATA: pt_ready=1. On pt_valid&pt_ready, perform one step with m=pt_bit, ca=1, cb=0; bit_count++. If pt_last, go to PAD. No step when pt_valid=0.
  - PAD: one step every cycle, pad index j=0..255 (8-bit counter). m = (j==0), ca = (j<128), cb=0. After the step with j=255, go to DONE.
  - DONE: state_out <= updated state, done=1 for one cycle, busy=0, then IDLE.
- start is ignored when not IDLE.
- Step definition (S = 293-bit register, all terms use pre-step values of that line's sources, applied in this order):
  - S289^=S235^S230
  - S230^=S196^S193
  - S193^=S160^S154
  - S154^=S111^S107
  - S107^=S66^S61
  - S61^=S23^S0
  - ks = S12 ^ S154 ^ maj(S235,S61,S193) ^ ch(S230,S111,S66), computed with the updated values.
  - f = S0 ^ ~S107 ^ maj(S244,S23,S160) ^ (ca&S196) ^ (cb&ks) ^ m
  - Shift: S[i]<=S[i+1] for i<292; S292<=f.
  - maj(x,y,z)=xy^xz^yz; ch(x,y,z)=xy^(~x)z.
- Ciphertext: ct_bit = pt_bit ^ ks of that step. Registered: ct_valid and ct_bit appear the cycle after the accepting edge (latency 1). No ct backpressure; the consumer must always accept.
- pt_last with a zero-length message is not possible; msg_empty covers that case.
- Total cycles from start to done: 1 + plen (at full rate) + 256 + 1.
- bit_count saturates at all-ones and does not wrap.
- Reset mid-operation aborts immediately to reset values; no partial state_out update.

Test Plan:
- Reset: assert rst=0 mid-DATA -> all outputs 0 in same cycle; after release, FSM IDLE, pt_ready=0.
- Zero state, single bit: start with state_in=0, msg_empty=0; feed pt_bit=1 with pt_last=1 -> ct_bit=1 next cycle (ks=0); done exactly 257 cycles after the accept cycle; bit_count=1.
- Empty message: start with msg_empty=1 -> pt_ready never asserts, no ct_valid, done 258 cycles after start; state_out matches C reference model.
- Bubbled stream: 64 bits with pt_valid toggling 1/0 -> exactly 64 ct_valid pulses; ct stream and state_out identical to a gap-free run of the same bits.
- Known-answer: state_in from AD-stage golden vector, 128-bit plaintext 0x00..0F bytes -> ct bits and state_out match ACORN-128 reference model bit-exactly.
- start during DATA/PAD -> ignored; results unchanged versus a run with no extra start.
